// File: rtl/mem_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_streamer
// Description : Reads ceil(byte_len/BPW) words from a synchronous memory port
//               starting at base_addr and streams them out one byte at a time
//               on a valid/ack interface, in a selectable byte order.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_streamer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 14,
    parameter int LEN_W      = 16,
    parameter int MEM_LAT    = 1,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  byte_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ack
);

    localparam int c_bpw       = DATA_W / 8;
    localparam int c_bidx_w    = (c_bpw > 1) ? $clog2(c_bpw) : 1;
    localparam int c_lat_w     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_bidx_w-1:0] c_bidx_last = c_bidx_w'(c_bpw - 1);
    localparam logic [c_bidx_w-1:0] c_bidx_one  = c_bidx_w'(1);
    localparam logic [c_lat_w-1:0]  c_lat_init  = c_lat_w'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    localparam logic [c_lat_w-1:0]  c_lat_one   = c_lat_w'(1);
    localparam logic [LEN_W-1:0]    c_len_one   = LEN_W'(1);
    localparam logic [ADDR_W-1:0]   c_addr_one  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_rem;
    logic [c_lat_w-1:0]  r_lat;
    logic [c_bidx_w-1:0] r_bidx;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                w_load;
    logic                w_capture;
    logic                w_take;
    logic                w_next_word;

    // Byte order only changes which end of the word is presented and which way it moves.
    generate
        if (BIG_ENDIAN != 0) begin : g_be
            assign out_data    = r_shift[DATA_W-1 -: 8];
            assign w_shift_nxt = r_shift << 8;
        end else begin : g_le
            assign out_data    = r_shift[7:0];
            assign w_shift_nxt = r_shift >> 8;
        end
    endgenerate

    assign busy      = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_SEND);
    assign done      = (r_state == S_DONE);
    assign mem_rd    = (r_state == S_FETCH);
    assign out_valid = (r_state == S_SEND);
    assign mem_addr  = r_addr;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort beats everything while busy, a new start wins over abort when idle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_take      = 1'b0;
        w_next_word = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (byte_len == '0) ? S_DONE : S_FETCH;
                end else if (abort) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (MEM_LAT == 0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_lat == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (out_ack) begin
                    w_take = 1'b1;
                    if (r_rem == c_len_one) begin
                        w_state_nxt = S_DONE;
                    end else if (r_bidx == c_bidx_last) begin
                        w_next_word = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: command latch, latency counter, word shift register and byte counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_lat   <= '0;
            r_bidx  <= '0;
            r_shift <= '0;
        end else begin
            if (w_load) begin
                r_addr <= base_addr;
                r_rem  <= byte_len;
            end
            if (r_state == S_FETCH) begin
                r_lat <= c_lat_init;
            end else if ((r_state == S_WAIT) && (r_lat != '0)) begin
                r_lat <= r_lat - c_lat_one;
            end
            if (w_capture) begin
                r_shift <= mem_data;
                r_bidx  <= '0;
            end else if (w_take) begin
                r_shift <= w_shift_nxt;
                r_bidx  <= r_bidx + c_bidx_one;
                r_rem   <= r_rem - c_len_one;
            end
            if (w_next_word) begin
                r_addr <= r_addr + c_addr_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_streamer
// Description : Scoreboard bench for mem_byte_streamer. Instance A is 16-bit,
//               little-endian, latency 1; instance B is 32-bit, big-endian,
//               latency 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_byte_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- instance A ----------------
    logic        rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0, ack_a = 1'b1;
    logic [13:0] base_a = '0;
    logic [15:0] len_a = '0;
    logic        busy_a, done_a, mem_rd_a, out_valid_a;
    logic [13:0] mem_addr_a;
    logic [15:0] mem_data_a = '0;
    logic [7:0]  out_data_a;

    mem_byte_streamer #(.DATA_W(16), .ADDR_W(14), .LEN_W(16), .MEM_LAT(1), .BIG_ENDIAN(0)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a),
        .base_addr(base_a), .byte_len(len_a), .busy(busy_a), .done(done_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ack(ack_a)
    );

    function automatic logic [15:0] mem_a(input logic [13:0] a);
        if (a == 14'h0010) return 16'hBEEF;
        if (a == 14'h0011) return 16'h1234;
        return {2'b00, a} ^ 16'h5A00;
    endfunction

    // One-cycle synchronous RAM model.
    always @(posedge clk) if (mem_rd_a) mem_data_a <= mem_a(mem_addr_a);

    // ---------------- instance B ----------------
    logic        rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0, ack_b = 1'b1;
    logic [13:0] base_b = '0;
    logic [15:0] len_b = '0;
    logic        busy_b, done_b, mem_rd_b, out_valid_b;
    logic [13:0] mem_addr_b;
    logic [31:0] mem_data_b = '0, stage1_b = '0;
    logic [7:0]  out_data_b;

    mem_byte_streamer #(.DATA_W(32), .ADDR_W(14), .LEN_W(16), .MEM_LAT(2), .BIG_ENDIAN(1)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
        .base_addr(base_b), .byte_len(len_b), .busy(busy_b), .done(done_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ack(ack_b)
    );

    // Two-stage pipelined RAM model.
    always @(posedge clk) begin
        stage1_b   <= (mem_addr_b == 14'h0005) ? 32'h11223344 : 32'h0;
        mem_data_b <= stage1_b;
    end

    // ---------------- scoreboards / monitors ----------------
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [13:0] rd_q_a[$];
    int rd_cnt_a = 0, first_a = -1, last_ack_a = -1, first_b = -1;

    // Monitor A: count reads, pop and compare on every accepted byte, hold-check while stalled.
    always @(negedge clk) begin
        if (mem_rd_a) begin
            rd_cnt_a++;
            rd_q_a.push_back(mem_addr_a);
        end
        if (out_valid_a) begin
            if (first_a < 0) first_a = cyc;
            if (exp_a.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_byte_a: got %h expected none", out_data_a);
            end else if (ack_a) begin
                check("byte_a", 32'(out_data_a), 32'(exp_a.pop_front()));
                last_ack_a = cyc;
            end else begin
                check("hold_a", 32'(out_data_a), 32'(exp_a[0]));
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (out_valid_b) begin
            if (first_b < 0) first_b = cyc;
            if (exp_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_byte_b: got %h expected none", out_data_b);
            end else if (ack_b) begin
                check("byte_b", 32'(out_data_b), 32'(exp_b.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a_cmd(input logic [13:0] b, input logic [15:0] l, output int t0);
        rd_cnt_a = 0;
        rd_q_a.delete();
        first_a = -1;
        last_ack_a = -1;
        tick();
        base_a = b; len_a = l; start_a = 1'b1;
        t0 = cyc;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_done_a: got no done expected done within 200 cycles");
        end
    endtask

    task automatic check_reads_a(input string name, input int n, input logic [13:0] a0, input logic [13:0] a1);
        check({name, "_rd_cnt"}, 32'(rd_cnt_a), 32'(n));
        if (n > 0) check({name, "_rd_addr0"}, 32'(rd_q_a[0]), 32'(a0));
        if (n > 1) check({name, "_rd_addr1"}, 32'(rd_q_a[1]), 32'(a1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        int t0, dc, k;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_a_outputs", 32'({busy_a, done_a, mem_rd_a, out_valid_a, mem_addr_a, out_data_a}), 32'h0);
        check("reset_b_outputs", 32'({busy_b, done_b, mem_rd_b, out_valid_b, mem_addr_b, out_data_b}), 32'h0);
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Test 1: four bytes from two words.
        exp_a.push_back(8'hEF); exp_a.push_back(8'hBE); exp_a.push_back(8'h34); exp_a.push_back(8'h12);
        start_a_cmd(14'h0010, 16'd4, t0);
        wait_done_a(dc);
        check("t1_first_valid", 32'(first_a), 32'(t0 + 3));
        check("t1_done_cycle", 32'(dc), 32'(last_ack_a + 1));
        check("t1_busy", 32'(busy_a), 32'h0);
        check_reads_a("t1", 2, 14'h0010, 14'h0011);
        check("t1_all_bytes", 32'(exp_a.size()), 32'h0);

        // Abort while in DONE clears done.
        tick(); abort_a = 1'b1;
        tick(); abort_a = 1'b0;
        @(negedge clk);
        check("abort_clears_done", 32'(done_a), 32'h0);

        // Test 2: partial last word, with an ignored start while busy.
        exp_a.push_back(8'hEF); exp_a.push_back(8'hBE); exp_a.push_back(8'h34);
        start_a_cmd(14'h0010, 16'd3, t0);
        tick();
        base_a = 14'h0000; len_a = 16'd2; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a(dc);
        check_reads_a("t2", 2, 14'h0010, 14'h0011);
        check("t2_all_bytes", 32'(exp_a.size()), 32'h0);
        check("t2_done_cycle", 32'(dc), 32'(last_ack_a + 1));

        // Test 3: zero length.
        start_a_cmd(14'h0010, 16'd0, t0);
        wait_done_a(dc);
        check("t3_done_cycle", 32'(dc), 32'(t0 + 1));
        repeat (4) tick();
        check("t3_rd_cnt", 32'(rd_cnt_a), 32'h0);
        check("t3_no_valid", 32'(first_a), 32'hFFFF_FFFF);

        // Test 4: address wrap.
        exp_a.push_back(8'hFF); exp_a.push_back(8'h65); exp_a.push_back(8'h00); exp_a.push_back(8'h5A);
        start_a_cmd(14'h3FFF, 16'd4, t0);
        wait_done_a(dc);
        check_reads_a("t4", 2, 14'h3FFF, 14'h0000);
        check("t4_all_bytes", 32'(exp_a.size()), 32'h0);

        // Test 5: stall mid-word, then abort, then a clean rerun.
        ack_a = 1'b0;
        exp_a.push_back(8'hEF); exp_a.push_back(8'hBE); exp_a.push_back(8'h34); exp_a.push_back(8'h12);
        start_a_cmd(14'h0010, 16'd4, t0);
        k = 0;
        while (!out_valid_a && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL timeout_valid_a: got no out_valid expected out_valid");
        end
        tick(); ack_a = 1'b1;
        tick(); ack_a = 1'b0;
        repeat (5) tick();
        abort_a = 1'b1;
        tick(); abort_a = 1'b0;
        @(negedge clk);
        check("t5_abort_outputs", 32'({out_valid_a, busy_a, done_a, mem_rd_a}), 32'h0);
        check("t5_remaining_exp", 32'(exp_a.size()), 32'd3);
        exp_a.delete();
        ack_a = 1'b1;
        repeat (3) tick();
        exp_a.push_back(8'hEF); exp_a.push_back(8'hBE); exp_a.push_back(8'h34); exp_a.push_back(8'h12);
        start_a_cmd(14'h0010, 16'd4, t0);
        wait_done_a(dc);
        check("t5_rerun_first", 32'(first_a), 32'(t0 + 3));
        check("t5_rerun_all_bytes", 32'(exp_a.size()), 32'h0);
        check_reads_a("t5", 2, 14'h0010, 14'h0011);

        // Test 6: 32-bit big-endian, latency 2, reset during the second byte.
        exp_b.push_back(8'h11); exp_b.push_back(8'h22); exp_b.push_back(8'h33); exp_b.push_back(8'h44);
        tick();
        base_b = 14'h0005; len_b = 16'd4; start_b = 1'b1;
        t0 = cyc;
        tick();
        start_b = 1'b0;
        k = 0;
        while (cyc < t0 + 5 && k < 20) begin
            tick();
            k++;
        end
        rst_b = 1'b1;
        #1;
        check("t6_first_valid", 32'(first_b), 32'(t0 + 4));
        check("t6_byte22_pending", 32'(exp_b.size()), 32'd3);
        check("t6_reset_outputs", 32'({busy_b, done_b, mem_rd_b, out_valid_b, mem_addr_b, out_data_b}), 32'h0);
        repeat (2) tick();
        rst_b = 1'b0;
        exp_b.delete();
        repeat (10) tick();
        @(negedge clk);
        check("t6_idle_after_reset", 32'({busy_b, done_b, out_valid_b}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
